twiddle_sched: RTL

- Sequencer that owns the 16-entry twiddle ROM (const_rom) and streams twiddle factors to the butterfly PE for radix-2 DIF FFT frames of N = 2^LOG2N points.
- Generates the ROM address and enable, absorbs the ROM's 2-cycle read latency, and presents twiddles on a valid/ready stream.
- Stage and last-beat tags travel with each twiddle.
- Runs a programmable number of back-to-back frames per start.

---
 rtl/twiddle_sched.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/twiddle_sched.sv
// twiddle_sched: owns the 16-entry twiddle ROM and streams radix-2 DIF twiddles with stage/last tags.
// Optional macro TW_CONJ_EN adds an inv input that conjugates (negates imag, saturating) for IFFT runs.
module twiddle_sched #(
    parameter int LOG2N      = 5,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [7:0]              cfg_frames,
`ifdef TW_CONJ_EN
    input  logic                    inv,
`endif
    output logic                    busy,
    output logic                    done,
    output logic                    rom_en,
    output logic [3:0]              rom_addr,
    input  logic [2*DATA_WIDTH-1:0] rom_data,
    output logic [2*DATA_WIDTH-1:0] tw_data,
    output logic [2:0]              tw_stage,
    output logic                    tw_last,
    output logic                    tw_valid,
    input  logic                    tw_ready
);
    localparam int HALF = 1 << (LOG2N - 1);
    localparam int JW   = (LOG2N > 1) ? LOG2N - 1 : 1;
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int TW   = 2 * DATA_WIDTH;
    localparam logic [JW-1:0] J_MAX   = JW'(HALF - 1);
    localparam logic [2:0]    S_MAX   = 3'(LOG2N - 1);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_MAX = PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [JW-1:0] j_cnt;
    logic [2:0]    s_cnt;
    logic [7:0]    frame_cnt;
    logic [7:0]    frame_last;
    logic          issue;
    logic          beat_last;
    logic          run_end;

    logic          vld_p0, vld_p1;
    logic [2:0]    stage_p0, stage_p1;
    logic          last_p0, last_p1;
    logic [1:0]    inflight;

    logic [TW-1:0] mem_data  [FIFO_DEPTH];
    logic [2:0]    mem_stage [FIFO_DEPTH];
    logic          mem_last  [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occ;
    logic          push, pop;
    logic [TW-1:0] wr_data;

    // Exponent of W_N for butterfly j at stage s, folded into the half-period ROM.
    function automatic logic [3:0] tw_addr(input logic [JW-1:0] j, input logic [2:0] s);
        logic [JW-1:0] mask;
        mask = JW'((HALF >> s) - 1);
        return 4'((j & mask) << s);
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PW'(1);
    endfunction

`ifdef TW_CONJ_EN
    function automatic logic signed [DATA_WIDTH-1:0] neg_sat(input logic signed [DATA_WIDTH-1:0] x);
        if (x == {1'b1, {(DATA_WIDTH-1){1'b0}}})
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        return -x;
    endfunction

    logic inv_q;
    always_ff @(posedge clk) begin
        if (!rst_n)
            inv_q <= 1'b0;
        else if (state == IDLE && start)
            inv_q <= inv;
    end

    assign wr_data = {rom_data[TW-1:DATA_WIDTH],
                      inv_q ? neg_sat(rom_data[DATA_WIDTH-1:0]) : rom_data[DATA_WIDTH-1:0]};
`else
    assign wr_data = rom_data;
`endif

    assign beat_last = (j_cnt == J_MAX) && (s_cnt == S_MAX);
    assign run_end   = beat_last && (frame_cnt == frame_last);
    assign inflight  = {1'b0, vld_p0} + {1'b0, vld_p1};
    assign occ       = (CW + 1)'(fifo_count) + (CW + 1)'(inflight);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = RUN;
            end
            RUN: begin
                busy  = 1'b1;
                issue = (occ < DEPTH_C);
                if (issue && run_end)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (inflight == 2'd0 && fifo_count == '0)
                    state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            j_cnt      <= '0;
            s_cnt      <= '0;
            frame_cnt  <= '0;
            frame_last <= '0;
        end else if (state == IDLE && start) begin
            j_cnt      <= '0;
            s_cnt      <= '0;
            frame_cnt  <= '0;
            frame_last <= (cfg_frames == 8'd0) ? 8'd0 : cfg_frames - 8'd1;
        end else if (issue) begin
            if (j_cnt == J_MAX) begin
                j_cnt <= '0;
                if (s_cnt == S_MAX) begin
                    s_cnt     <= '0;
                    frame_cnt <= frame_cnt + 8'd1;
                end else begin
                    s_cnt <= s_cnt + 3'd1;
                end
            end else begin
                j_cnt <= j_cnt + JW'(1);
            end
        end
    end

    assign rom_en   = issue;
    assign rom_addr = tw_addr(j_cnt, s_cnt);

    // p0/p1: tags shadow the ROM's two-cycle read; data arrives alongside vld_p1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= issue;
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge clk) begin
        stage_p0 <= s_cnt;
        last_p0  <= beat_last;
        stage_p1 <= stage_p0;
        last_p1  <= last_p0;
    end

    assign push = vld_p1;
    assign pop  = tw_valid && tw_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr]  <= wr_data;
            mem_stage[wr_ptr] <= stage_p1;
            mem_last[wr_ptr]  <= last_p1;
        end
    end

    assign tw_valid = (fifo_count != '0);
    assign tw_data  = tw_valid ? mem_data[rd_ptr]  : '0;
    assign tw_stage = tw_valid ? mem_stage[rd_ptr] : 3'd0;
    assign tw_last  = tw_valid ? mem_last[rd_ptr]  : 1'b0;

endmodule
